i32_to_f32_converter: RTL and testbench
=======================================

I32_TO_F32_CONVERTER -- requirements
Module: i32_to_f32_converter

Interface
REQ-001 SHALL have parameter N, default 32: input integer width, legal 8..32.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port IN_VALID  input  1  IN_DATA/SIGNED_IN valid.
REQ-005 SHALL have port IN_READY  output  1  block can accept an operand.
REQ-006 SHALL have port IN_DATA  input  N  integer operand.
REQ-007 SHALL have port SIGNED_IN  input  1  operand encoding: 1 = two's complement, 0 = unsigned.
REQ-008 SHALL have port OUT_VALID  output  1  R/INEXACT valid.
REQ-009 SHALL have port OUT_READY  input  1  consumer accepts R.
REQ-010 SHALL have port R  output  32  IEEE-754 single result.
REQ-011 SHALL have port INEXACT  output  1  precision was discarded.

Function
REQ-012 SHALL implement states IDLE, NORM, PACK, DONE.
REQ-013 SHALL assert IN_READY only in IDLE; input accepted on a cycle with IN_VALID and IN_READY both high (cycle t).
REQ-014 SHALL, on accept, latch the sign (SIGNED_IN & IN_DATA[N-1]) and the N-bit magnitude (two's-complement negation when the sign is set; -2^(N-1) yields magnitude 2^(N-1)) and set the exponent register to 127+N-1.
REQ-015 SHALL, on accept of a zero magnitude, go directly to DONE with R=0x00000000 and INEXACT=0, giving OUT_VALID at t+1.
REQ-016 SHALL, otherwise, enter NORM at t+1; each NORM cycle with magnitude MSB clear shifts the magnitude left 1 and decrements the exponent; MSB set moves to PACK.
REQ-017 SHALL, in PACK, form the mantissa from magnitude bits [N-2:0], left-aligned into 23 bits (zero-padded when N<24); for N>24, guard = bit N-25 and sticky = OR of the bits below it.
REQ-018 SHALL assert OUT_VALID at t+3+L, where L = leading zeros of the magnitude.
REQ-019 SHALL set INEXACT = guard | sticky (0 when N<=24).
REQ-020 SHALL have final exponent field 127+(N-1)-L, with the rounding carry applied; overflow is impossible for N<=32.
REQ-021 SHALL hold R, INEXACT and OUT_VALID stable in DONE until OUT_READY is high.
REQ-022 SHALL, on DONE with OUT_READY high, deassert OUT_VALID next cycle and return to IDLE; no input is accepted in that cycle.
REQ-023 SHALL ignore IN_VALID and IN_DATA outside IDLE.

Reset
REQ-024 SHALL, on a rising CLK with RST_N low, enter IDLE with IN_READY=1, OUT_VALID=0, R=0 and INEXACT=0, regardless of state.
REQ-025 SHALL discard any in-flight conversion on reset and produce no OUT_VALID for it.

Configuration
REQ-026 SHALL, with macro F32_ROUND_NEAREST_EN defined, round to nearest-even in PACK: increment the mantissa when guard & (sticky | mantissa LSB); a mantissa carry-out zeroes the mantissa and increments the exponent.
REQ-027 SHALL, without F32_ROUND_NEAREST_EN, truncate; INEXACT and the latency of REQ-018 are identical in both builds.

Verification
REQ-028 SHALL cover: IN_DATA=1, SIGNED_IN=0 -> R=0x3F800000, INEXACT=0, OUT_VALID at t+34.
REQ-029 SHALL cover: IN_DATA=0xFFFFFFFF, SIGNED_IN=1 -> R=0xBF800000; the same input with SIGNED_IN=0 -> R=0x4F800000 with macro or R=0x4F7FFFFF without, INEXACT=1 in both builds.
REQ-030 SHALL cover: IN_DATA=0x80000000, SIGNED_IN=1 -> R=0xCF000000, OUT_VALID at t+3; IN_DATA=0 -> R=0x00000000, OUT_VALID at t+1.
REQ-031 SHALL cover: IN_DATA=0x01000001, SIGNED_IN=0 -> R=0x4B800000, INEXACT=1, in both builds (tie rounds to even).
REQ-032 SHALL cover: OUT_READY held low 5 cycles after OUT_VALID -> R stable and IN_READY=0 throughout; OUT_READY high -> IDLE and IN_READY=1 next cycle.
REQ-033 SHALL cover: RST_N low for 1 cycle during NORM of IN_DATA=1 -> IN_READY=1 and OUT_VALID=0 next cycle; the stale result is never presented.

Source files
------------

// File: rtl/i32_to_f32_converter_if.sv
// Handshake bundle for i32_to_f32_converter: operand channel in, result channel out.
// master drives operands and result acceptance; slave is the converter.
interface i32_to_f32_converter_if #(
   parameter int unsigned N = 32
);
   logic          IN_VALID;
   logic          IN_READY;
   logic [N-1:0]  IN_DATA;
   logic          SIGNED_IN;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [31:0]   R;
   logic          INEXACT;

   modport master (
      output IN_VALID, IN_DATA, SIGNED_IN, OUT_READY,
      input  IN_READY, OUT_VALID, R, INEXACT
   );

   modport slave (
      input  IN_VALID, IN_DATA, SIGNED_IN, OUT_READY,
      output IN_READY, OUT_VALID, R, INEXACT
   );
endinterface

// File: rtl/i32_to_f32_converter.sv
// Multi-cycle N-bit integer to IEEE-754 single converter (one leading zero per NORM cycle).
// Define F32_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module i32_to_f32_converter #(
   parameter int unsigned N = 32
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   i32_to_f32_converter_if.slave    cvt_io
);

   typedef enum logic [1:0] {StIdle, StNorm, StPack, StDone} state_e;

   localparam logic [7:0] ExpInit = 8'(126 + N);

   state_e        state_q, state_d;
   logic          sign_q, sign_d;
   logic [N-1:0]  mag_q, mag_d;
   logic [7:0]    exp_q, exp_d;
   logic [31:0]   r_q, r_d;
   logic          inexact_q, inexact_d;

   logic          in_sign;
   logic [N-1:0]  in_mag;
   logic [54:0]   mag_ext;
   logic [22:0]   mant;
   logic          guard, sticky, round_up;
   logic [23:0]   mant_sum;
   logic [7:0]    exp_fin;

   assign in_sign = cvt_io.SIGNED_IN & cvt_io.IN_DATA[N-1];
   assign in_mag  = in_sign ? -cvt_io.IN_DATA : cvt_io.IN_DATA;

   // Bits below the hidden one, left-aligned so mantissa/guard/sticky sit at fixed positions.
   assign mag_ext = {mag_q[N-2:0], {(56 - N){1'b0}}};
   assign mant    = mag_ext[54:32];
   assign guard   = mag_ext[31];
   assign sticky  = |mag_ext[30:0];

`ifdef F32_ROUND_NEAREST_EN
   assign round_up = guard & (sticky | mant[0]);
`else
   assign round_up = 1'b0;
`endif

   assign mant_sum = {1'b0, mant} + {23'd0, round_up};
   assign exp_fin  = exp_q + {7'd0, mant_sum[23]};

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      mag_d     = mag_q;
      exp_d     = exp_q;
      r_d       = r_q;
      inexact_d = inexact_q;
      unique case (state_q)
         StIdle: begin
            if (cvt_io.IN_VALID) begin
               sign_d = in_sign;
               mag_d  = in_mag;
               exp_d  = ExpInit;
               if (in_mag == '0) begin
                  r_d       = '0;
                  inexact_d = 1'b0;
                  state_d   = StDone;
               end else begin
                  state_d = StNorm;
               end
            end
         end
         StNorm: begin
            if (mag_q[N-1]) begin
               state_d = StPack;
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 8'd1;
            end
         end
         StPack: begin
            r_d       = {sign_q, exp_fin, mant_sum[22:0]};
            inexact_d = guard | sticky;
            state_d   = StDone;
         end
         StDone: begin
            if (cvt_io.OUT_READY) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= StIdle;
         sign_q    <= 1'b0;
         mag_q     <= '0;
         exp_q     <= '0;
         r_q       <= '0;
         inexact_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         mag_q     <= mag_d;
         exp_q     <= exp_d;
         r_q       <= r_d;
         inexact_q <= inexact_d;
      end
   end

   assign cvt_io.IN_READY  = (state_q == StIdle);
   assign cvt_io.OUT_VALID = (state_q == StDone);
   assign cvt_io.R         = r_q;
   assign cvt_io.INEXACT   = inexact_q;

endmodule

// File: tb/tb_i32_to_f32_converter.sv
// Self-checking bench for i32_to_f32_converter (N=32): directed table, handshake and
// reset corner cases, then random operands against an arithmetic reference model.
module tb_i32_to_f32_converter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   i32_to_f32_converter_if #(.N(32)) cvt_if ();

   i32_to_f32_converter #(.N(32)) u_dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .cvt_io (cvt_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        sgn;
      logic [31:0] r;
      logic        inx;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Reference: locate the top set bit, shift to a 24-bit significand, round from the remainder.
   function automatic void model(input logic [31:0] d, input logic s, output logic [31:0] r,
                                 output logic inx, output int lat);
      logic            neg;
      longint unsigned mag, sig, rem, half;
      int              p, e, sh;
      neg = s && d[31];
      mag = neg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
      r   = '0;
      inx = 1'b0;
      lat = 1;
      if (mag == 0) return;
      p = 0;
      for (int i = 0; i < 33; i++) if (mag >= (64'd1 << i)) p = i;
      e = 127 + p;
      if (p <= 23) begin
         sig = mag << (23 - p);
      end else begin
         sh   = p - 23;
         sig  = mag >> sh;
         rem  = mag - (sig << sh);
         half = 64'd1 << (sh - 1);
         inx  = (rem != 0);
`ifdef F32_ROUND_NEAREST_EN
         if (rem > half || (rem == half && sig[0])) sig = sig + 1;
         if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
         end
`else
         if (half == 0) inx = inx;
`endif
      end
      r   = {neg, 8'(e), sig[22:0]};
      lat = 3 + (31 - p);
   endfunction

   // One full transaction; optionally holds OUT_READY low for `hold` cycles while poking IN_VALID.
   task automatic run_op(input string name, input logic [31:0] d, input logic s,
                         input logic [31:0] exp_r, input logic exp_inx, input int exp_lat,
                         input int hold);
      int lat;
      @(negedge clk);
      chk({name, "/in_ready"}, 32'(cvt_if.IN_READY), 32'd1);
      cvt_if.IN_VALID  = 1'b1;
      cvt_if.IN_DATA   = d;
      cvt_if.SIGNED_IN = s;
      @(negedge clk);
      cvt_if.IN_VALID = 1'b0;
      cvt_if.IN_DATA  = $urandom;
      lat = 1;
      while (!cvt_if.OUT_VALID && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "/R"}, cvt_if.R, exp_r);
      chk({name, "/INEXACT"}, 32'(cvt_if.INEXACT), 32'(exp_inx));
      for (int h = 0; h < hold; h++) begin
         cvt_if.IN_VALID  = 1'b1;
         cvt_if.IN_DATA   = $urandom;
         cvt_if.SIGNED_IN = 1'($urandom);
         @(negedge clk);
         chk({name, "/hold_R"}, cvt_if.R, exp_r);
         chk({name, "/hold_in_ready"}, 32'(cvt_if.IN_READY), 32'd0);
         chk({name, "/hold_out_valid"}, 32'(cvt_if.OUT_VALID), 32'd1);
      end
      cvt_if.IN_VALID  = 1'b0;
      cvt_if.OUT_READY = 1'b1;
      @(negedge clk);
      cvt_if.OUT_READY = 1'b0;
      chk({name, "/drain_out_valid"}, 32'(cvt_if.OUT_VALID), 32'd0);
      chk({name, "/drain_in_ready"}, 32'(cvt_if.IN_READY), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[$];
      logic [31:0] d, er;
      logic        s, ei;
      int          el, seen;

      checks = 0;
      errors = 0;
      cvt_if.IN_VALID  = 1'b0;
      cvt_if.IN_DATA   = '0;
      cvt_if.SIGNED_IN = 1'b0;
      cvt_if.OUT_READY = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset/in_ready", 32'(cvt_if.IN_READY), 32'd1);
      chk("reset/out_valid", 32'(cvt_if.OUT_VALID), 32'd0);
      chk("reset/R", cvt_if.R, 32'd0);
      chk("reset/inexact", 32'(cvt_if.INEXACT), 32'd0);
      rst_n = 1'b1;

      vecs.push_back('{32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 34});
      vecs.push_back('{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 34});
`ifdef F32_ROUND_NEAREST_EN
      vecs.push_back('{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3});
      vecs.push_back('{32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 1'b1, 4});
`else
      vecs.push_back('{32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF, 1'b1, 3});
      vecs.push_back('{32'h7FFF_FFFF, 1'b1, 32'h4EFF_FFFF, 1'b1, 4});
`endif
      vecs.push_back('{32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3});
      vecs.push_back('{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1});
      vecs.push_back('{32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10});
      vecs.push_back('{32'h0000_0005, 1'b1, 32'h40A0_0000, 1'b0, 32});
      vecs.push_back('{32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 32});

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].sgn, vecs[i].r, vecs[i].inx,
                vecs[i].lat, 0);

      // Result must stay parked while the consumer stalls.
      run_op("stall", 32'h0000_1234, 1'b0, 32'h4591_A000, 1'b0, 22, 5);

      // Reset mid-normalisation drops the conversion entirely.
      @(negedge clk);
      cvt_if.IN_VALID  = 1'b1;
      cvt_if.IN_DATA   = 32'h0000_0001;
      cvt_if.SIGNED_IN = 1'b0;
      @(negedge clk);
      cvt_if.IN_VALID = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midreset/in_ready", 32'(cvt_if.IN_READY), 32'd1);
      chk("midreset/out_valid", 32'(cvt_if.OUT_VALID), 32'd0);
      chk("midreset/R", cvt_if.R, 32'd0);
      chk("midreset/inexact", 32'(cvt_if.INEXACT), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (cvt_if.OUT_VALID) seen++;
      end
      chk("midreset/stale_valid_cycles", 32'(seen), 32'd0);
      run_op("post_reset", 32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 34, 0);

      for (int k = 0; k < 200; k++) begin
         d = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 3) == 0) d = ~d;
         s = 1'($urandom);
         model(d, s, er, ei, el);
         run_op($sformatf("rand%0d_%h_%0d", k, d, s), d, s, er, ei, el,
                ($urandom_range(0, 7) == 0) ? 2 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
